trace_capture: RTL and testbench

TRACE_CAPTURE -- requirements
Module: trace_capture

---
 rtl/trace_capture.sv | 201 ++++++++++++++++++++
 tb/tb_trace_capture.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/trace_capture.sv
// CPU execution trace buffer: captures {pc, instr, wb_result} each run cycle into a
// circular buffer and stops on halt_pc, a cycle limit or (with TRACE_SELF_LOOP_EN) a self-loop.
module trace_capture #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 16,
    parameter int MAX_CYCLES = 4096,
    parameter int LOOP_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_W-1:0]        pc,
    input  logic [DATA_W-1:0]        instr,
    input  logic [DATA_W-1:0]        wb_result,
    input  logic [DATA_W-1:0]        halt_pc,
    input  logic [$clog2(DEPTH)-1:0] rd_idx,
    output logic [DATA_W-1:0]        rd_pc,
    output logic [DATA_W-1:0]        rd_instr,
    output logic [DATA_W-1:0]        rd_wb,
    output logic                     rd_valid,
    output logic                     running,
    output logic                     done,
    output logic [1:0]               halt_cause,
    output logic [31:0]              cycle_count,
    output logic [$clog2(DEPTH):0]   entry_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_CYCLES < 1 || LOOP_LIMIT < 1) begin : g_bad_cfg
            $error("trace_capture: illegal parameter set");
        end
    endgenerate

    state_t                  r_state;
    logic [3*DATA_W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0]        r_wr_ptr;
    logic [CNT_W-1:0]        r_entry_count;
    logic [31:0]             r_cycle_count;
    logic [1:0]              r_halt_cause;
    logic                    r_running;
    logic                    r_done;
    logic [DATA_W-1:0]       r_rd_pc;
    logic [DATA_W-1:0]       r_rd_instr;
    logic [DATA_W-1:0]       r_rd_wb;
    logic                    r_rd_valid;

    logic                    w_wr_en;
    logic                    w_restart;
    logic                    w_hit_pc;
    logic                    w_hit_max;
    logic                    w_hit_loop;
    logic                    w_halt;
    logic [1:0]              w_cause;
    logic [PTR_W-1:0]        w_rd_slot;
    logic                    w_rd_ok;

    assign w_wr_en   = (r_state == S_RUN) && !reset;
    assign w_restart = start && (r_state != S_RUN);
    assign w_hit_pc  = (pc == halt_pc);
    assign w_hit_max = ((r_cycle_count + 32'd1) >= 32'(MAX_CYCLES));
    assign w_rd_slot = r_wr_ptr - r_entry_count[PTR_W-1:0] + rd_idx;
    assign w_rd_ok   = ({1'b0, rd_idx} < r_entry_count);

`ifdef TRACE_SELF_LOOP_EN
    // Loop length counts repeats of the previous pc, so LOOP_LIMIT same-pc cycles need LOOP_LIMIT-1 repeats.
    logic [DATA_W-1:0] r_prev_pc;
    logic              r_prev_vld;
    logic [31:0]       r_loop_cnt;
    logic [31:0]       w_loop_next;

    assign w_loop_next = (r_prev_vld && (pc == r_prev_pc)) ? (r_loop_cnt + 32'd1) : 32'd0;
    assign w_hit_loop  = (w_loop_next >= 32'(LOOP_LIMIT - 1));

    // Previous-pc tracking for self-loop detection.
    always_ff @(posedge clk) begin
        if (reset || w_restart) begin
            r_prev_pc  <= '0;
            r_prev_vld <= 1'b0;
            r_loop_cnt <= 32'd0;
        end else if (r_state == S_RUN) begin
            r_prev_pc  <= pc;
            r_prev_vld <= 1'b1;
            r_loop_cnt <= w_loop_next;
        end else begin
            r_prev_pc  <= r_prev_pc;
            r_prev_vld <= r_prev_vld;
            r_loop_cnt <= r_loop_cnt;
        end
    end
`else
    assign w_hit_loop = 1'b0;
`endif

    // Halt priority: halt_pc, then self-loop, then cycle limit.
    always_comb begin
        w_halt  = 1'b1;
        w_cause = 2'd0;
        if (w_hit_pc) begin
            w_cause = 2'd1;
        end else if (w_hit_loop) begin
            w_cause = 2'd3;
        end else if (w_hit_max) begin
            w_cause = 2'd2;
        end else begin
            w_halt  = 1'b0;
            w_cause = 2'd0;
        end
    end

    // Trace storage; not reset, contents are qualified by entry_count.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= {wb_result, instr, pc};
        end
    end

    // Run control FSM with registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_wr_ptr      <= '0;
            r_entry_count <= '0;
            r_cycle_count <= 32'd0;
            r_halt_cause  <= 2'd0;
            r_running     <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_RUN;
                        r_wr_ptr      <= '0;
                        r_entry_count <= '0;
                        r_cycle_count <= 32'd0;
                        r_halt_cause  <= 2'd0;
                        r_running     <= 1'b1;
                        r_done        <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_wr_ptr      <= r_wr_ptr + 1'b1;
                    r_cycle_count <= r_cycle_count + 32'd1;
                    if (r_entry_count != CNT_W'(DEPTH)) begin
                        r_entry_count <= r_entry_count + 1'b1;
                    end
                    if (w_halt) begin
                        r_state      <= S_DONE;
                        r_halt_cause <= w_cause;
                        r_running    <= 1'b0;
                        r_done       <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            endcase
        end
    end

    // Registered readout, oldest entry at index 0, zero data when out of range.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
            r_rd_wb    <= '0;
            r_rd_valid <= 1'b0;
        end else if (w_rd_ok) begin
            r_rd_pc    <= r_mem[w_rd_slot][DATA_W-1:0];
            r_rd_instr <= r_mem[w_rd_slot][2*DATA_W-1:DATA_W];
            r_rd_wb    <= r_mem[w_rd_slot][3*DATA_W-1:2*DATA_W];
            r_rd_valid <= 1'b1;
        end else begin
            r_rd_pc    <= '0;
            r_rd_instr <= '0;
            r_rd_wb    <= '0;
            r_rd_valid <= 1'b0;
        end
    end

    assign rd_pc       = r_rd_pc;
    assign rd_instr    = r_rd_instr;
    assign rd_wb       = r_rd_wb;
    assign rd_valid    = r_rd_valid;
    assign running     = r_running;
    assign done        = r_done;
    assign halt_cause  = r_halt_cause;
    assign cycle_count = r_cycle_count;
    assign entry_count = r_entry_count;

endmodule

// File: tb/tb_trace_capture.sv
// Directed bench for trace_capture (DEPTH=16, MAX_CYCLES=40, LOOP_LIMIT=4).
module tb_trace_capture;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] pc, instr, wb_result, halt_pc;
    logic [3:0]  rd_idx;
    logic [31:0] rd_pc, rd_instr, rd_wb;
    logic        rd_valid, running, done;
    logic [1:0]  halt_cause;
    logic [31:0] cycle_count;
    logic [4:0]  entry_count;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0]  idx;
        logic        valid;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] ewb;
    } rd_vec_t;

    rd_vec_t tab_a [5];
    rd_vec_t tab_b [3];

    trace_capture #(.DATA_W(32), .DEPTH(16), .MAX_CYCLES(40), .LOOP_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .start(start), .pc(pc), .instr(instr),
        .wb_result(wb_result), .halt_pc(halt_pc), .rd_idx(rd_idx),
        .rd_pc(rd_pc), .rd_instr(rd_instr), .rd_wb(rd_wb), .rd_valid(rd_valid),
        .running(running), .done(done), .halt_cause(halt_cause),
        .cycle_count(cycle_count), .entry_count(entry_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_pc(input logic [31:0] v);
        pc        = v;
        instr     = {16'hC0DE, v[15:0]};
        wb_result = ~v;
    endtask

    // mode 0: pc = 4*(k-1); mode 1: 0,4,8 then stuck at 8
    function automatic logic [31:0] gen_pc(input int mode, input int k);
        if (mode == 1 && k > 3) return 32'h8;
        return 32'(4 * (k - 1));
    endfunction

    task automatic do_run(input int mode, input logic [31:0] hpc, input int mid_start, output int k);
        @(negedge clk);
        halt_pc = hpc;
        start   = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        k = 1;
        set_pc(gen_pc(mode, k));
        for (int n = 0; n < 200; n++) begin
            @(posedge clk); #1;
            if (done) return;
            k++;
            set_pc(gen_pc(mode, k));
            start = (k == mid_start);
            if (k == mid_start + 1 && mid_start > 0) check("running_after_mid_start", 32'(running), 32'd1);
        end
        check("run_timeout", 32'd0, 32'd1);
    endtask

    task automatic read_vec(input rd_vec_t v, input string tag);
        @(negedge clk);
        rd_idx = v.idx;
        @(posedge clk); #1;
        check({tag, "_valid"}, 32'(rd_valid), 32'(v.valid));
        check({tag, "_pc"},    rd_pc,    v.epc);
        check({tag, "_instr"}, rd_instr, v.einstr);
        check({tag, "_wb"},    rd_wb,    v.ewb);
    endtask

    initial begin
        int k;
        tab_a[0] = '{4'd0,  1'b1, 32'h0000_0000, 32'hC0DE_0000, 32'hFFFF_FFFF};
        tab_a[1] = '{4'd5,  1'b1, 32'h0000_0014, 32'hC0DE_0014, 32'hFFFF_FFEB};
        tab_a[2] = '{4'd10, 1'b1, 32'h0000_0028, 32'hC0DE_0028, 32'hFFFF_FFD7};
        tab_a[3] = '{4'd11, 1'b0, 32'h0,         32'h0,         32'h0};
        tab_a[4] = '{4'd15, 1'b0, 32'h0,         32'h0,         32'h0};
        tab_b[0] = '{4'd0,  1'b1, 32'h0000_0060, 32'hC0DE_0060, 32'hFFFF_FF9F};
        tab_b[1] = '{4'd1,  1'b1, 32'h0000_0064, 32'hC0DE_0064, 32'hFFFF_FF9B};
        tab_b[2] = '{4'd15, 1'b1, 32'h0000_009C, 32'hC0DE_009C, 32'hFFFF_FF63};

        reset = 1'b1; start = 1'b0; rd_idx = 4'd0; halt_pc = 32'hFFFF_FFF0;
        set_pc(32'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        check("rst_running", 32'(running), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cause", 32'(halt_cause), 32'd0);
        check("rst_cycles", cycle_count, 32'd0);
        check("rst_entries", 32'(entry_count), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_pc", rd_pc, 32'd0);

        // halt on pc 0x28
        do_run(0, 32'h28, 0, k);
        check("hpc_done", 32'(done), 32'd1);
        check("hpc_running", 32'(running), 32'd0);
        check("hpc_cause", 32'(halt_cause), 32'd1);
        check("hpc_cycles", cycle_count, 32'd11);
        check("hpc_entries", 32'(entry_count), 32'd11);
        for (int i = 0; i < 5; i++) read_vec(tab_a[i], $sformatf("hpc_rd%0d", i));

        // cycle limit with wrap
        do_run(0, 32'hFFFF_FFF0, 0, k);
        check("max_cause", 32'(halt_cause), 32'd2);
        check("max_cycles", cycle_count, 32'd40);
        check("max_entries", 32'(entry_count), 32'd16);
        for (int i = 0; i < 3; i++) read_vec(tab_b[i], $sformatf("max_rd%0d", i));

        // self-loop
        do_run(1, 32'hFFFF_FFF0, 0, k);
`ifdef TRACE_SELF_LOOP_EN
        check("loop_cause", 32'(halt_cause), 32'd3);
        check("loop_cycles", cycle_count, 32'd6);
`else
        check("loop_cause", 32'(halt_cause), 32'd2);
        check("loop_cycles", cycle_count, 32'd40);
`endif

        // halt_pc on the limit cycle wins; start mid-run ignored
        do_run(0, 32'h9C, 20, k);
        check("prio_cause", 32'(halt_cause), 32'd1);
        check("prio_cycles", cycle_count, 32'd40);

        // reset mid-run
        @(negedge clk);
        halt_pc = 32'hFFFF_FFF0; start = 1'b1; rd_idx = 4'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_running", 32'(running), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mrst_running", 32'(running), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_cause", 32'(halt_cause), 32'd0);
        check("mrst_cycles", cycle_count, 32'd0);
        check("mrst_entries", 32'(entry_count), 32'd0);
        check("mrst_rd_valid", 32'(rd_valid), 32'd0);
        check("mrst_rd_pc", rd_pc, 32'd0);
        do_run(0, 32'h8, 0, k);
        check("after_cause", 32'(halt_cause), 32'd1);
        check("after_cycles", cycle_count, 32'd3);
        check("after_entries", 32'(entry_count), 32'd3);
        read_vec(tab_a[0], "after_rd0");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
